// File: rtl/fifo_channel_buffer_pkg.sv
// Shared types and the pointer wrap helper for the multi-channel FIFO buffer.
package fifo_types;

    typedef enum logic [1:0] {
        FIFO_IDLE,
        FIFO_ENQ,
        FIFO_DEQ,
        FIFO_ENQ_DEQ
    } fifo_op_e;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int fifo_ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_channel_buffer_core.sv
// One FIFO channel: storage, pointers, count, registered head word, flush.
// Define FIFO_HWM_EN to add the per-channel high-water-mark register.
module fifo_chan_core
    import fifo_types::*;
#(
    parameter int width_p        = 8,
    parameter int depth_p        = 6,
    parameter int afull_thresh_p = depth_p - 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         enq,
    input  logic [width_p-1:0]           data_in,
    input  logic                         yumi,
    input  logic                         flush,
    output logic                         full,
    output logic                         valid,
    output logic [width_p-1:0]           data,
    output logic [$clog2(depth_p+1)-1:0] count,
    output logic                         almost_full,
    output logic [$clog2(depth_p+1)-1:0] hwm
);
    localparam int PW = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int CW = $clog2(depth_p + 1);

    logic [width_p-1:0] mem [depth_p];
    logic [PW-1:0]      rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0]      count_r, count_nxt;
    logic [width_p-1:0] head_r, head_nxt;
    logic               deq;
    fifo_op_e           op;

    assign valid = (count_r != '0);
    assign full  = (count_r == CW'(depth_p));
    assign deq   = valid & yumi;
    assign count = count_r;
    assign data  = head_r;

    assign rd_nxt = PW'(fifo_ptr_inc(int'(rd_ptr), depth_p));
    assign wr_nxt = PW'(fifo_ptr_inc(int'(wr_ptr), depth_p));

    always_comb begin
        op        = FIFO_IDLE;
        count_nxt = count_r;
        head_nxt  = head_r;
        if (enq && deq)  op = FIFO_ENQ_DEQ;
        else if (enq)    op = FIFO_ENQ;
        else if (deq)    op = FIFO_DEQ;
        case (op)
            FIFO_ENQ: begin
                count_nxt = count_r + 1'b1;
                if (count_r == '0) head_nxt = data_in;
            end
            FIFO_DEQ: begin
                count_nxt = count_r - 1'b1;
                head_nxt  = mem[rd_nxt];
            end
            // With one word held, the new word becomes the head directly.
            FIFO_ENQ_DEQ: head_nxt = (count_r == CW'(1)) ? data_in : mem[rd_nxt];
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_r     <= '0;
            head_r      <= '0;
            almost_full <= 1'b0;
            for (int i = 0; i < depth_p; i++) mem[i] <= '0;
        end else if (flush) begin
            // Head word deliberately left stale; valid drops via count.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_r     <= '0;
            almost_full <= (afull_thresh_p <= 0);
        end else begin
            if (enq) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_nxt;
            end
            if (deq) rd_ptr <= rd_nxt;
            count_r     <= count_nxt;
            head_r      <= head_nxt;
            almost_full <= (int'(count_nxt) >= afull_thresh_p);
        end
    end

`ifdef FIFO_HWM_EN
    logic [CW-1:0] hwm_r;
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush) hwm_r <= '0;
        else if (count_nxt > hwm_r) hwm_r <= count_nxt;
    end
    assign hwm = hwm_r;
`else
    assign hwm = '0;
`endif

endmodule

// File: rtl/fifo_channel_buffer.sv
// Multi-channel FIFO: shared enqueue port steered by chan_i, per-channel dequeue.
// Define FIFO_HWM_EN to enable the per-channel high-water-mark outputs.
module fifo_channel_buffer
    import fifo_types::*;
#(
    parameter int width_p        = 8,
    parameter int depth_p        = 6,
    parameter int channels_p     = 4,
    parameter int afull_thresh_p = depth_p - 1
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [width_p-1:0]                            data_i,
    input  logic [((channels_p > 1) ? $clog2(channels_p) : 1)-1:0] chan_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    output logic [channels_p-1:0]                         valid_o,
    output logic [channels_p-1:0][width_p-1:0]            data_o,
    input  logic [channels_p-1:0]                         yumi_i,
    input  logic [channels_p-1:0]                         flush_i,
    output logic [channels_p-1:0][$clog2(depth_p+1)-1:0]  count_o,
    output logic [channels_p-1:0]                         almost_full_o,
    output logic [channels_p-1:0][$clog2(depth_p+1)-1:0]  hwm_o
);
    localparam int CHW = (channels_p > 1) ? $clog2(channels_p) : 1;

    logic [channels_p-1:0] full;
    logic [channels_p-1:0] enq;

    // Depends only on registered state, chan_i and flush_i; never on valid_i.
    assign ready_o = ~full[chan_i] & ~flush_i[chan_i];

    for (genvar c = 0; c < channels_p; c++) begin : g_chan
        assign enq[c] = valid_i & ready_o & (chan_i == CHW'(c));

        fifo_chan_core #(
            .width_p        (width_p),
            .depth_p        (depth_p),
            .afull_thresh_p (afull_thresh_p)
        ) u_core (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .enq         (enq[c]),
            .data_in     (data_i),
            .yumi        (yumi_i[c]),
            .flush       (flush_i[c]),
            .full        (full[c]),
            .valid       (valid_o[c]),
            .data        (data_o[c]),
            .count       (count_o[c]),
            .almost_full (almost_full_o[c]),
            .hwm         (hwm_o[c])
        );
    end

endmodule

// File: tb/tb_fifo_channel_buffer.sv
// Directed self-checking bench for fifo_channel_buffer (default parameters).
module tb_fifo_channel_buffer;
    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [7:0]      data_i;
    logic [1:0]      chan_i;
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      valid_o;
    logic [3:0][7:0] data_o;
    logic [3:0]      yumi_i;
    logic [3:0]      flush_i;
    logic [3:0][2:0] count_o;
    logic [3:0]      almost_full_o;
    logic [3:0][2:0] hwm_o;

    int checks = 0;
    int errors = 0;

    fifo_channel_buffer dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .chan_i(chan_i),
        .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .yumi_i(yumi_i), .flush_i(flush_i), .count_o(count_o),
        .almost_full_o(almost_full_o), .hwm_o(hwm_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i = 1'b0; yumi_i = '0; flush_i = '0;
    endtask

    task automatic do_enq(input logic [1:0] ch, input logic [7:0] d);
        chan_i = ch; data_i = d; valid_i = 1'b1;
        step();
        idle();
    endtask

    task automatic do_deq(input int ch);
        yumi_i = '0; yumi_i[ch] = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; idle(); chan_i = '0; data_i = '0;
        step(); step();
        reset_n_i = 1'b1;
        #1;
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %h want 0", count_o); end
        checks++; if (valid_o !== 4'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
        checks++; if (almost_full_o !== 4'b0) begin errors++; $display("FAIL reset_afull got %b want 0", almost_full_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
        checks++; if (hwm_o !== '0) begin errors++; $display("FAIL reset_hwm got %h want 0", hwm_o); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        do_enq(2, 8'h11);
        checks++; if (valid_o[2] !== 1'b1 || data_o[2] !== 8'h11) begin
            errors++; $display("FAIL basic_first got v=%b d=%h want v=1 d=11", valid_o[2], data_o[2]); end
        do_enq(2, 8'h22);
        do_enq(2, 8'h33);
        checks++; if (count_o[2] !== 3'd3) begin errors++; $display("FAIL basic_count got %0d want 3", count_o[2]); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_o[2] !== exp[i]) begin errors++; $display("FAIL basic_order%0d got %h want %h", i, data_o[2], exp[i]); end
            do_deq(2);
        end
        checks++; if (count_o[2] !== 3'd0 || valid_o[2] !== 1'b0) begin
            errors++; $display("FAIL basic_empty got c=%0d v=%b want c=0 v=0", count_o[2], valid_o[2]); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 6; i++) begin
            do_enq(0, 8'hA0 + 8'(i));
            if (i == 3) begin
                checks++; if (almost_full_o[0] !== 1'b0) begin errors++; $display("FAIL afull_at4 got %b want 0", almost_full_o[0]); end
            end
            if (i == 4) begin
                checks++; if (almost_full_o[0] !== 1'b1) begin errors++; $display("FAIL afull_at5 got %b want 1", almost_full_o[0]); end
            end
        end
        chan_i = 2'd0; #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ready_o); end
        chan_i = 2'd1; #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL other_ready got %b want 1", ready_o); end
        do_enq(1, 8'h77);
        checks++; if (count_o[1] !== 3'd1) begin errors++; $display("FAIL other_count got %0d want 1", count_o[1]); end
        // Full channel with same-cycle yumi still refuses the word.
        chan_i = 2'd0; data_i = 8'hFF; valid_i = 1'b1; yumi_i = 4'b0001;
        step(); idle();
        checks++; if (count_o[0] !== 3'd5) begin errors++; $display("FAIL full_nobypass got %0d want 5", count_o[0]); end
        for (int i = 1; i < 6; i++) begin
            checks++; if (data_o[0] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_drain%0d got %h want %h", i, data_o[0], 8'hA0 + 8'(i)); end
            do_deq(0);
        end
        checks++; if (valid_o[0] !== 1'b0) begin errors++; $display("FAIL full_7th_written got v=%b want 0", valid_o[0]); end
        do_deq(1);
    endtask

    task automatic test_wrap();
        logic [7:0] exp [6] = '{8'h34, 8'h35, 8'h40, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 6; i++) do_enq(3, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            checks++; if (data_o[3] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL wrap_a%0d got %h want %h", i, data_o[3], 8'h30 + 8'(i)); end
            do_deq(3);
        end
        for (int i = 0; i < 4; i++) do_enq(3, 8'h40 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            checks++; if (data_o[3] !== exp[i]) begin errors++; $display("FAIL wrap_b%0d got %h want %h", i, data_o[3], exp[i]); end
            do_deq(3);
        end
        checks++; if (count_o[3] !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", count_o[3]); end
    endtask

    task automatic test_back_to_back();
        do_enq(1, 8'hAA);
        chan_i = 2'd1; data_i = 8'hBB; valid_i = 1'b1; yumi_i = 4'b0010;
        step(); idle();
        checks++; if (data_o[1] !== 8'hBB || count_o[1] !== 3'd1) begin
            errors++; $display("FAIL simul_c1 got d=%h c=%0d want d=BB c=1", data_o[1], count_o[1]); end
        // Enqueue ch2 while dequeuing ch1 in the same cycle.
        chan_i = 2'd2; data_i = 8'hC2; valid_i = 1'b1; yumi_i = 4'b0010;
        step(); idle();
        checks++; if (count_o[1] !== 3'd0 || count_o[2] !== 3'd1 || data_o[2] !== 8'hC2) begin
            errors++; $display("FAIL indep got c1=%0d c2=%0d d2=%h want 0 1 C2", count_o[1], count_o[2], data_o[2]); end
        do_deq(2);
    endtask

    task automatic test_flush();
        do_enq(0, 8'h01); do_enq(0, 8'h02); do_enq(0, 8'h03);
        flush_i = 4'b0001; chan_i = 2'd0; data_i = 8'hEE; valid_i = 1'b1; yumi_i = 4'b0001;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ready_o); end
        step(); idle();
        checks++; if (count_o[0] !== 3'd0 || valid_o[0] !== 1'b0) begin
            errors++; $display("FAIL flush_clear got c=%0d v=%b want 0 0", count_o[0], valid_o[0]); end
        checks++; if (data_o[0] !== 8'h01) begin errors++; $display("FAIL flush_stale got %h want 01", data_o[0]); end
        do_enq(0, 8'h5C); do_enq(0, 8'h6D);
        checks++; if (data_o[0] !== 8'h5C) begin errors++; $display("FAIL flush_first got %h want 5C", data_o[0]); end
        do_deq(0);
        checks++; if (data_o[0] !== 8'h6D) begin errors++; $display("FAIL flush_second got %h want 6D", data_o[0]); end
        do_deq(0);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) do_enq(2'(c), 8'(16 * c + i + 1));
        checks++; if (count_o !== {3'd4, 3'd4, 3'd4, 3'd4}) begin errors++; $display("FAIL mid_fill got %h want all 4", count_o); end
`ifdef FIFO_HWM_EN
        checks++; if (hwm_o[3] !== 3'd4) begin errors++; $display("FAIL hwm_pre got %0d want 4", hwm_o[3]); end
`endif
        reset_n_i = 1'b0; step(); reset_n_i = 1'b1;
        checks++; if (count_o !== '0 || valid_o !== 4'b0) begin
            errors++; $display("FAIL mid_reset got c=%h v=%b want 0", count_o, valid_o); end
        checks++; if (hwm_o !== '0) begin errors++; $display("FAIL mid_hwm got %h want 0", hwm_o); end
        for (int i = 0; i < 4; i++) do_enq(3, 8'hD0 + 8'(i));
        checks++; if (data_o[3] !== 8'hD0) begin errors++; $display("FAIL mid_first got %h want D0", data_o[3]); end
`ifdef FIFO_HWM_EN
        checks++; if (hwm_o[3] !== 3'd4) begin errors++; $display("FAIL hwm_refill got %0d want 4", hwm_o[3]); end
`else
        checks++; if (hwm_o !== '0) begin errors++; $display("FAIL hwm_off got %h want 0", hwm_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_channel_buffer.md
Name: fifo_channel_buffer

Overview:
Multi-channel successor to the single-queue FIFO. It holds channels_p independent FIFOs of arbitrary depth, which need not be a power of two. One shared valid-ready enqueue port is steered by a channel id. Each channel has its own registered valid-yumi output, occupancy count, almost-full flag and flush. It sits between the HE front-end dispatcher and per-lane compute units.

Parameters:
width_p, 8, bits per stored word
depth_p, 6, words per channel; any value >= 2
channels_p, 4, number of independent queues; >= 1
afull_thresh_p, depth_p-1, almost_full_o[c] asserts when count >= this value

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset
data_i  in  width_p  enqueue word
chan_i  in  max(1,$clog2(channels_p))  target channel; must be stable while valid_i=1
valid_i  in  1  enqueue request
ready_o  out  1  target channel can accept this cycle
valid_o  out  [channels_p]  per-channel head valid
data_o  out  [channels_p][width_p]  per-channel registered head word
yumi_i  in  [channels_p]  per-channel dequeue
flush_i  in  [channels_p]  per-channel synchronous clear
count_o  out  [channels_p][$clog2(depth_p+1)]  occupancy
almost_full_o  out  [channels_p]  count >= afull_thresh_p

Behaviour:
- Clock and reset: single clock clk_i. Reset reset_n_i is synchronous and active-low, sampled on posedge clk_i.
- Reset state: all read/write pointers, counts, valid_o, data_o, almost_full_o and storage are 0.
- Reset mid-operation discards all contents; the first accepted enqueue after reset is the first word out.
- ready_o = ~full[chan_i] & ~flush_i[chan_i]. It is combinational from chan_i, flush_i and registered state. There is no valid_i→ready_o path.
- enq[c] = valid_i & ready_o & (chan_i==c). deq[c] = valid_o[c] & yumi_i[c]. yumi_i[c] with valid_o[c]=0 is ignored.
- Pointers range 0..depth_p-1 and wrap explicitly to 0 after depth_p-1; there is no extra MSB.
- full/empty derive from the count register: full = count==depth_p, empty = count==0.
- count_o[c] update: +1 on enq only, -1 on deq only, unchanged on both.
- valid_o[c] = (count[c] != 0) from registers.
- data_o[c] is a registered head buffer:
  - enq into an empty channel: data_o = data_i; valid_o rises the next cycle (1-cycle latency).
  - deq only: data_o loads the entry at rd_ptr+1 (wrapped).
  - enq & deq with count==1: data_o = data_i.
  - enq & deq with count>1: data_o = mem[rd_ptr+1]; data_i is written at wr_ptr.
- A full channel with a same-cycle yumi still refuses the enqueue, since ready_o is registered-state based; there is no bypass.
- flush_i[c]: next cycle pointers and count are 0, valid_o[c]=0, and data_o[c] holds its stale value.
  - flush overrides a same-cycle deq on c; the yumi has no effect.
  - While flush_i[c]=1, ready_o for chan_i==c is 0, so no silent loss.
- Channels are fully independent: enqueue to channel a and dequeue from channel b in the same cycle both complete.
- Storage is written only at the enqueue location. Reads never use combinational memory out.

Optional Feature:
- Macro: FIFO_HWM_EN.
- Defined: adds per-channel high-water-mark register hwm_o[channels_p][$clog2(depth_p+1)].
  - Updates to max(hwm, next count) each cycle.
  - Cleared by reset or by flush_i[c].
- Undefined: hwm_o is driven '0 and no registers are inferred.

Decomposition:
- Package fifo_types holds:
  - function fifo_ptr_inc(ptr, depth) implementing the wrap.
  - typedef fifo_op_e {FIFO_IDLE, FIFO_ENQ, FIFO_DEQ, FIFO_ENQ_DEQ}, used as the case selector.
- Sub-module fifo_chan_core: one channel containing storage, pointers, count, head buffer, flush and HWM.
- The top instantiates channels_p copies via generate and does chan_i decode and ready_o muxing.

Test Plan:
1. Reset, then enqueue 0x11,0x22,0x33 to ch2 → valid_o[2] next cycle, data_o[2]=0x11; yumi ×3 yields 0x11,0x22,0x33; count_o[2] ends 0.
2. Fill ch0 with 6 words → ready_o=0 for chan_i=0, almost_full_o[0] at count 5; ch1 is still accepted; a 7th word is not written.
3. Wrap: 6 enq, 4 deq, 4 enq, 6 deq on ch3 → strict FIFO order across the wrap at pointer 5→0.
4. count==1 on ch1 holding 0xAA, simultaneous enq 0xBB and yumi → next data_o[1]=0xBB, count stays 1.
5. flush_i[0] with count 3 plus a same-cycle valid_i to ch0 → ready_o=0, next count 0, valid_o[0]=0; a subsequent enq 0x5C is output first.
6. Reset asserted mid-stream with 4 words in each channel → all counts 0 next cycle; with FIFO_HWM_EN, hwm_o=0 after reset and hwm_o[3]=4 after refilling.
